pipe_share_ctrl: RTL and testbench
==================================

# pipe_share_ctrl

Controller that shares one fixed-latency pipelined datapath among NUM_REQS requesters. It arbitrates each cycle with round-robin priority and drives the shared `enable` of the datapath's pipe-register chain. It carries a valid and requester tag alongside every stage, and steers each result back to the requester that issued it. The whole pipe stalls when the owning requester backpressures. It sits between per-lane issue logic and any shared multi-cycle unit built from pipe registers with DEPTH = LATENCY.

## Interface
- NUM_REQS, 4: requester count (≥1).
- DATAW, 32: payload width into and out of the datapath.
- LATENCY, 3: datapath depth in cycles (≥1). Must equal the DEPTH of the external pipe-register chain.
- TAGW, derived: max(1, clog2(NUM_REQS)).

- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  NUM_REQS  per-requester request valid.
- req_data  in  NUM_REQS*DATAW  request payloads. Requester i occupies bits [i*DATAW +: DATAW].
- req_ready  out  NUM_REQS  per-requester accept. One-hot or zero.
- pipe_enable  out  1  shared enable for every stage of the external datapath.
- pipe_in  out  DATAW  payload into datapath stage 0.
- pipe_out  in  DATAW  datapath result at stage LATENCY-1.
- rsp_valid  out  NUM_REQS  per-requester result valid. One-hot or zero.
- rsp_data  out  DATAW  result, broadcast to all requesters. Equals pipe_out.
- rsp_ready  in  NUM_REQS  per-requester result accept.
- busy  out  1  any stage occupied.

## Operation
- Shadow chain: vld[0..LATENCY-1] and tag[0..LATENCY-1]. It advances only when pipe_enable=1, in lockstep with the datapath.
- Head = stage LATENCY-1.
  - rsp_valid[i] = vld[L-1] && tag[L-1]==i.
  - stall = vld[L-1] && !rsp_ready[tag[L-1]].
  - pipe_enable = !stall.
- Arbiter:
  - Round-robin. The search starts at last_grant+1 mod NUM_REQS.
  - Candidate g is the first i with req_valid[i].
  - req_ready[g] = pipe_enable. All other req_ready bits are 0.
  - Grant is combinational. rsp_ready→req_ready is a permitted combinational path.
- Handshake fire = req_valid[g] && req_ready[g]. On fire:
  - vld[0]<=1, tag[0]<=g.
  - last_grant<=g.
- When pipe_enable=1 and there is no fire, vld[0]<=0 (a bubble).
- pipe_in = req_data[g] whenever any req_valid is set. Otherwise pipe_in is don't-care and is driven as 0.
- Stall freezes all stages, including bubbles. There is no bubble collapse.
- last_grant changes only on fire. A stalled candidate keeps priority.
- busy = OR of vld[].
- NUM_REQS=1: the arbiter degenerates to a pass-through. TAGW=1 and the tag is always 0.

## Timing
- Reset values:
  - vld=0, tag=0.
  - last_grant=NUM_REQS-1, so requester 0 wins first.
  - rsp_valid=0, busy=0, pipe_enable=1.
  - req_ready follows req_valid combinationally from the first cycle after reset deasserts.
- While reset=1: req_ready=0.
- Latency: a fire in cycle t gives rsp_valid in cycle t+LATENCY, when there are no stalls. Each stall cycle adds one.
- Throughput: one fire per cycle when rsp_ready is held high.
- Simultaneous pop and push: a head consumed in the same cycle as a new fire is legal and does not stall.
- Rules for rsp_valid:
  - rsp_valid, rsp_data and tag stay stable while rsp_ready is low.
  - Requesters must not make rsp_ready depend on their own req_valid.
- Reset mid-operation: all in-flight entries are discarded. No rsp_valid pulses after reset, and last_grant is restored.
- The datapath's own reset must not be relied on. Validity is carried solely by vld[].

## Test plan
- Single request, LATENCY=3: req_valid=0001, data 0xA5 at cycle 5 → req_ready[0]=1 in cycle 5; rsp_valid=0001 with rsp_data=f(0xA5) in cycle 8; busy high in cycles 6-8.
- Fairness: req_valid=1111 held and rsp_ready=1111 → grants 0,1,2,3,0,… one per cycle; responses return in the same order with matching tags.
- Backpressure: stream from requester 2 with rsp_ready[2]=0 for 4 cycles at the head → pipe_enable=0 and req_ready=0 for those 4 cycles; no data lost or duplicated; order preserved.
- Stalled priority: requesters 1 and 3 valid during a stall with last_grant=0 → requester 1 fires on the first cycle after the stall clears, then requester 3.
- Reset mid-flight: 3 entries in flight, assert reset for 1 cycle → no rsp_valid afterwards; next request from requester 0 is granted first.
- NUM_REQS=1, LATENCY=1: continuous stream of 16 words with random rsp_ready → outputs match inputs in order, fire only when rsp_ready or the pipe is empty.

Source files
------------

// File: rtl/pipe_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_share_ctrl
// Purpose  : Shares one fixed-latency pipelined datapath among NUM_REQS
//            requesters. Each cycle a round-robin arbiter picks a requester.
//            The controller drives the shared stage enable of the external
//            pipe-register chain. It keeps a valid/tag shadow chain in
//            lockstep with that chain and steers each result back to the
//            requester that issued it. The whole pipe freezes while the
//            requester owning the head result holds off.
// Ports    :
//   clk, reset        clock, synchronous active-high reset
//   req_valid[N]      per-requester request valid
//   req_data[N*DATAW] request payloads, requester i at [i*DATAW +: DATAW]
//   req_ready[N]      per-requester accept (one-hot or zero)
//   pipe_enable       shared enable for every datapath stage
//   pipe_in[DATAW]    payload into datapath stage 0
//   pipe_out[DATAW]   datapath result at its last stage
//   rsp_valid[N]      per-requester result valid (one-hot or zero)
//   rsp_data[DATAW]   result broadcast to all requesters (= pipe_out)
//   rsp_ready[N]      per-requester result accept
//   busy              any stage occupied
// Revision : 1.0 - initial release
// ============================================================================
module pipe_share_ctrl #(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 32,
  parameter int LATENCY  = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       req_valid,
  input  logic [NUM_REQS*DATAW-1:0] req_data,
  output logic [NUM_REQS-1:0]       req_ready,
  output logic                      pipe_enable,
  output logic [DATAW-1:0]          pipe_in,
  input  logic [DATAW-1:0]          pipe_out,
  output logic [NUM_REQS-1:0]       rsp_valid,
  output logic [DATAW-1:0]          rsp_data,
  input  logic [NUM_REQS-1:0]       rsp_ready,
  output logic                      busy
);

  localparam int TAGW = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  // After reset the search must begin at requester 0, so the pointer
  // starts on the last requester.
  localparam logic [TAGW-1:0] c_last_grant_init = TAGW'(NUM_REQS - 1);

  // --------------------------------------------------------------------------
  // Shadow chain: one valid bit and one requester tag per datapath stage.
  // Stage LATENCY-1 is the head and lines up with pipe_out.
  // --------------------------------------------------------------------------
  logic [LATENCY-1:0] r_vld;
  logic [TAGW-1:0]    r_tag [LATENCY];
  logic [TAGW-1:0]    r_last_grant;

  logic               w_head_vld;
  logic [TAGW-1:0]    w_head_tag;
  logic               w_head_ready;
  logic               w_stall;

  logic               w_any_req;
  logic               w_hi_found;
  logic               w_lo_found;
  logic [TAGW-1:0]    w_hi_idx;
  logic [TAGW-1:0]    w_lo_idx;
  logic [TAGW-1:0]    w_grant;
  logic               w_fire;

  assign w_head_vld = r_vld[LATENCY-1];
  assign w_head_tag = r_tag[LATENCY-1];

  // Ready of the requester that owns the head result. Tags never exceed
  // NUM_REQS-1, so a compare loop avoids an out-of-range variable index.
  always_comb begin
    w_head_ready = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (w_head_tag == TAGW'(i)) begin
        w_head_ready = rsp_ready[i];
      end
    end
  end

  // A bubble at the head never stalls. Only an unaccepted valid result does.
  assign w_stall     = w_head_vld && !w_head_ready;
  assign pipe_enable = !w_stall;

  // --------------------------------------------------------------------------
  // Round-robin arbiter. The lowest valid index above last_grant wins.
  // If no valid index lies above it, the search wraps to the lowest valid
  // index overall. This gives the same result as a search starting at
  // last_grant+1 mod NUM_REQS.
  // --------------------------------------------------------------------------
  assign w_any_req = |req_valid;

  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (req_valid[i]) begin
        if (!w_hi_found && (TAGW'(i) > r_last_grant)) begin
          w_hi_found = 1'b1;
          w_hi_idx   = TAGW'(i);
        end
        if (!w_lo_found) begin
          w_lo_found = 1'b1;
          w_lo_idx   = TAGW'(i);
        end
      end
    end
    w_grant = w_hi_found ? w_hi_idx : w_lo_idx;
  end

  // The candidate is always a valid requester, so the handshake fires
  // exactly when someone is asking and the pipe is allowed to move.
  assign w_fire = w_any_req && pipe_enable && !reset;

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (w_fire && (w_grant == TAGW'(i))) begin
        req_ready[i] = 1'b1;
      end
    end
  end

  // The payload of the candidate goes to stage 0 even during a stall. The
  // datapath ignores it then, because its enable is low.
  always_comb begin
    pipe_in = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (w_any_req && (w_grant == TAGW'(i))) begin
        pipe_in = req_data[i*DATAW +: DATAW];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Shadow chain advance. The chain shifts only when the datapath does.
  // Stage 0 takes the fired request or a bubble. A stall freezes every
  // stage, bubbles included, so each entry stays aligned with its data.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld        <= '0;
      r_last_grant <= c_last_grant_init;
      for (int s = 0; s < LATENCY; s++) begin
        r_tag[s] <= '0;
      end
    end else if (pipe_enable) begin
      for (int s = LATENCY - 1; s > 0; s--) begin
        r_vld[s] <= r_vld[s-1];
        r_tag[s] <= r_tag[s-1];
      end
      r_vld[0] <= w_fire;
      r_tag[0] <= w_fire ? w_grant : '0;
      if (w_fire) begin
        r_last_grant <= w_grant;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Result steering
  // --------------------------------------------------------------------------
  generate
    for (genvar i = 0; i < NUM_REQS; i++) begin : g_rsp_valid
      assign rsp_valid[i] = w_head_vld && (w_head_tag == TAGW'(i));
    end
  endgenerate

  assign rsp_data = pipe_out;
  assign busy     = |r_vld;

endmodule
`default_nettype wire

// File: tb/tb_pipe_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_share_ctrl
// Purpose  : Self-checking bench for pipe_share_ctrl.
//            - Main instance: 4 requesters, LATENCY 3.
//            - Second instance: 1 requester, LATENCY 1.
//            Each instance has an external pipe-register datapath computing
//            f(x). A transaction-level model predicts every output: in-flight
//            entries sit in a queue stamped with an enabled-cycle count.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_share_ctrl;

  localparam int NR  = 4;
  localparam int DW  = 32;
  localparam int LAT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  function automatic logic [31:0] f(input logic [31:0] x);
    return {x[7:0], x[31:8]} ^ 32'h3C3C_5A5A;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- main DUT (4 requesters, LATENCY 3) ----------------
  logic              reset = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*DW-1:0]  req_data = '0;
  logic [NR-1:0]     req_ready;
  logic              pipe_enable;
  logic [DW-1:0]     pipe_in;
  logic [DW-1:0]     pipe_out;
  logic [NR-1:0]     rsp_valid;
  logic [DW-1:0]     rsp_data;
  logic [NR-1:0]     rsp_ready = '1;
  logic              busy;

  pipe_share_ctrl #(.NUM_REQS(NR), .DATAW(DW), .LATENCY(LAT)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .pipe_enable(pipe_enable), .pipe_in(pipe_in), .pipe_out(pipe_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .busy(busy)
  );

  // External datapath: LAT enabled pipe registers, f applied on entry, no reset.
  logic [DW-1:0] dp [LAT];
  always @(posedge clk) begin
    if (pipe_enable) begin
      dp[0] <= f(pipe_in);
      for (int s = 1; s < LAT; s++) dp[s] <= dp[s-1];
    end
  end
  assign pipe_out = dp[LAT-1];

  // ---------------- second DUT (1 requester, LATENCY 1) ----------------
  logic          reset1 = 1'b1;
  logic [0:0]    req_valid1 = '0;
  logic [DW-1:0] req_data1 = '0;
  logic [0:0]    req_ready1;
  logic          pipe_enable1;
  logic [DW-1:0] pipe_in1;
  logic [DW-1:0] pipe_out1;
  logic [0:0]    rsp_valid1;
  logic [DW-1:0] rsp_data1;
  logic [0:0]    rsp_ready1 = '0;
  logic          busy1;

  pipe_share_ctrl #(.NUM_REQS(1), .DATAW(DW), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset1),
    .req_valid(req_valid1), .req_data(req_data1), .req_ready(req_ready1),
    .pipe_enable(pipe_enable1), .pipe_in(pipe_in1), .pipe_out(pipe_out1),
    .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .rsp_ready(rsp_ready1),
    .busy(busy1)
  );

  logic [DW-1:0] dp1;
  always @(posedge clk) if (pipe_enable1) dp1 <= f(pipe_in1);
  assign pipe_out1 = dp1;

  // ---------------- transaction-level model of the main DUT ----------------
  // An entry issued while `ecount` enabled cycles had elapsed reaches the
  // head once LAT more enabled cycles have passed. It leaves when the head
  // is accepted.
  typedef struct {
    int          tag;
    logic [31:0] data;
    int          e;
  } ent_t;

  ent_t q[$];
  int   ecount = 0;
  int   m_last = NR - 1;

  initial begin : compare_proc
    bit          head_v, m_en, m_fire, m_pop, any;
    int          g;
    logic [31:0] m_data;
    logic [NR-1:0] exp_rv, exp_rr;
    forever begin
      @(negedge clk);
      m_en = 1'b1; m_fire = 1'b0; m_pop = 1'b0; g = 0; m_data = '0;
      if (reset) begin
        chk("rst_req_ready", 32'(req_ready), 32'h0);
      end else begin
        head_v = (q.size() > 0) && (q[0].e + LAT == ecount);
        exp_rv = head_v ? NR'(1 << q[0].tag) : '0;
        m_en   = !(head_v && !rsp_ready[q[0].tag]);
        any    = |req_valid;
        for (int k = 1; k <= NR; k++) begin
          int c;
          c = (m_last + k) % NR;
          if (req_valid[c]) begin g = c; break; end
        end
        exp_rr = (any && m_en) ? NR'(1 << g) : '0;
        chk("model_pipe_enable", 32'(pipe_enable), 32'(m_en));
        chk("model_req_ready",   32'(req_ready),   32'(exp_rr));
        chk("model_rsp_valid",   32'(rsp_valid),   32'(exp_rv));
        chk("model_busy",        32'(busy),        32'(q.size() > 0));
        if (head_v) chk("model_rsp_data", rsp_data, f(q[0].data));
        if (any) begin
          m_data = req_data[g*DW +: DW];
          chk("model_pipe_in", pipe_in, m_data);
        end
        m_fire = any && m_en;
        m_pop  = head_v && m_en;
      end
      @(posedge clk);
      if (reset) begin
        q.delete();
        m_last = NR - 1;
        ecount = 0;
      end else if (m_en) begin
        if (m_pop) void'(q.pop_front());
        if (m_fire) begin
          q.push_back('{tag: g, data: m_data, e: ecount});
          m_last = g;
        end
        ecount++;
      end
    end
  end

  // ---------------- second-instance stream with its own model ----------------
  bit done1 = 1'b0;
  initial begin : n1_proc
    logic [31:0] words [16];
    int sent, got, inflight;
    bit e_rr, pop;
    sent = 0; got = 0; inflight = 0;
    foreach (words[k]) words[k] = $urandom;
    repeat (3) @(posedge clk);
    #1 reset1 = 1'b0;
    for (int cyc = 0; cyc < 400 && got < 16; cyc++) begin
      @(posedge clk); #1;
      req_valid1 = (sent < 16);
      req_data1  = (sent < 16) ? words[sent] : '0;
      rsp_ready1 = 1'($urandom_range(0, 1));
      @(negedge clk);
      // LATENCY 1: the stage is the head; a new word enters only if it is
      // empty or its occupant is being taken this cycle.
      e_rr = req_valid1[0] && (inflight == 0 || rsp_ready1[0]);
      pop  = (inflight > 0) && rsp_ready1[0];
      chk("n1_req_ready", 32'(req_ready1), 32'(e_rr));
      chk("n1_rsp_valid", 32'(rsp_valid1), 32'(inflight > 0));
      if (pop) begin
        chk("n1_rsp_data", rsp_data1, f(words[got]));
        got++;
      end
      inflight = inflight - int'(pop) + int'(e_rr);
      if (e_rr) sent++;
    end
    chk("n1_words_received", 32'(got), 32'd16);
    done1 = 1'b1;
  end

  // ---------------- main stimulus ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  initial begin : stim
    // Reset: request lines high must not be accepted.
    req_valid = '1;
    repeat (3) cyc();
    @(negedge clk);
    chk("reset_hold_req_ready", 32'(req_ready), 32'h0);
    cyc(); reset = 1'b0; req_valid = '0;
    @(negedge clk);
    chk("reset_busy",        32'(busy),        32'h0);
    chk("reset_pipe_enable", 32'(pipe_enable), 32'h1);
    chk("reset_rsp_valid",   32'(rsp_valid),   32'h0);

    // Single request from requester 0 with payload 0xA5.
    cyc(); req_valid = 4'b0001; req_data = '0; req_data[31:0] = 32'hA5; rsp_ready = '1;
    @(negedge clk);
    chk("single_req_ready", 32'(req_ready), 32'h1);
    cyc(); req_valid = '0;
    @(negedge clk);
    chk("single_busy_t1", 32'(busy), 32'h1);
    chk("single_rsp_t1",  32'(rsp_valid), 32'h0);
    cyc();
    @(negedge clk);
    chk("single_rsp_t2",  32'(rsp_valid), 32'h0);
    cyc();
    @(negedge clk);
    chk("single_rsp_t3",  32'(rsp_valid), 32'h1);
    chk("single_rsp_data", rsp_data, 32'h993C_5A5A);
    chk("single_busy_t3", 32'(busy), 32'h1);
    cyc();
    @(negedge clk);
    chk("single_busy_t4", 32'(busy), 32'h0);

    // Reset with three entries in flight.
    for (int k = 0; k < 3; k++) begin
      cyc(); req_valid = 4'b0111;
      for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = $urandom;
    end
    cyc(); req_valid = '0; reset = 1'b1;
    cyc(); reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("midreset_no_rsp", 32'(rsp_valid), 32'h0);
      cyc();
    end

    // Fairness: all requesting, grants rotate from requester 0.
    req_valid = '1; rsp_ready = '1;
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = $urandom;
      @(negedge clk);
      chk("fair_grant", 32'(req_ready), 32'(1 << (k % NR)));
      cyc();
    end
    req_valid = '0;
    repeat (6) cyc();

    // Backpressure: stream from requester 2; its head is refused 4 cycles.
    for (int j = 0; j < 10; j++) begin
      req_valid = 4'b0100;
      req_data[2*DW +: DW] = $urandom;
      rsp_ready = (j >= 3 && j <= 6) ? 4'b1011 : 4'b1111;
      @(negedge clk);
      if (j >= 3 && j <= 6) begin
        chk("bp_pipe_enable", 32'(pipe_enable), 32'h0);
        chk("bp_req_ready",   32'(req_ready),   32'h0);
      end
      cyc();
    end
    req_valid = '0; rsp_ready = '1;
    repeat (6) cyc();

    // Stalled priority: last_grant=0, requesters 1 and 3 wait through a stall.
    req_valid = 4'b0001; req_data[0 +: DW] = $urandom; rsp_ready = 4'b1110;
    cyc(); req_valid = '0;
    cyc();
    cyc(); req_valid = 4'b1010;
    req_data[1*DW +: DW] = $urandom; req_data[3*DW +: DW] = $urandom;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("stall_req_ready", 32'(req_ready), 32'h0);
      cyc();
    end
    rsp_ready = '1;
    @(negedge clk);
    chk("stall_prio_first", 32'(req_ready), 32'h2);
    cyc();
    @(negedge clk);
    chk("stall_prio_second", 32'(req_ready), 32'h8);
    cyc(); req_valid = '0;
    repeat (6) cyc();

    // Randomized traffic with occasional resets.
    for (int k = 0; k < 3000; k++) begin
      req_valid = NR'($urandom);
      for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = $urandom;
      for (int i = 0; i < NR; i++) rsp_ready[i] = ($urandom_range(0, 9) < 8);
      reset = ($urandom_range(0, 299) == 0);
      cyc();
    end
    reset = 1'b0; req_valid = '0; rsp_ready = '1;
    repeat (8) cyc();

    for (int k = 0; k < 500 && !done1; k++) cyc();
    chk("n1_stream_done", 32'(done1), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
